// File: rtl/cis_pkg.sv
// Shared types and constants for the CIS readout slice.
package cis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    OUT  = 2'd2
  } cds_state_e;

  // Bit positions within the sticky err vector.
  localparam int unsigned ErrWidth   = 3;
  localparam int unsigned ErrSat     = 0;
  localparam int unsigned ErrOverlap = 1;
  localparam int unsigned ErrAbort   = 2;

endpackage

// File: rtl/cds_accumulator_if.sv
// Pattern/ADC inputs and pixel output handshake of the CDS accumulator.
interface cds_accumulator_if #(
  parameter int unsigned ADC_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SKIP_WIDTH = 16
);
  logic                         running;
  logic                         base_win;
  logic                         sig_win;
  logic [ADC_WIDTH-1:0]         adc_data;
  logic                         adc_valid;
  logic [SKIP_WIDTH-1:0]        num_skips;
  logic signed [ACC_WIDTH-1:0]  pix_data;
  logic                         pix_valid;
  logic                         pix_ready;
  logic                         busy;
  logic [SKIP_WIDTH-1:0]        skip_cnt;
  logic [2:0]                   err;

  modport master (
    output running, base_win, sig_win, adc_data, adc_valid, num_skips, pix_ready,
    input  pix_data, pix_valid, busy, skip_cnt, err
  );

  modport slave (
    input  running, base_win, sig_win, adc_data, adc_valid, num_skips, pix_ready,
    output pix_data, pix_valid, busy, skip_cnt, err
  );
endinterface

// File: rtl/sat_add.sv
// Signed two-operand add that clamps to the representable range on overflow.
module sat_add #(
  parameter int unsigned Width = 32
) (
  input  logic signed [Width-1:0] a_i,
  input  logic signed [Width-1:0] b_i,
  output logic signed [Width-1:0] sum_o,
  output logic                    ovf_o
);

  logic signed [Width:0] full;

  // One extra bit: overflow when the top two bits of the wide sum disagree.
  always_comb begin
    full  = {a_i[Width-1], a_i} + {b_i[Width-1], b_i};
    ovf_o = full[Width] ^ full[Width-1];
    if (!ovf_o) begin
      sum_o = full[Width-1:0];
    end else if (full[Width]) begin
      sum_o = {1'b1, {(Width-1){1'b0}}};
    end else begin
      sum_o = {1'b0, {(Width-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cds_accumulator.sv
// Correlated double sampling accumulator: sums (signal - baseline) over N skips
// per pixel and hands the result out on a valid/ready port.
module cds_accumulator
  import cis_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SKIP_WIDTH = 16
) (
  input logic              clk,
  input logic              reset,
  cds_accumulator_if.slave bus_io
);

  // Window sums are one bit narrower than acc so their difference always fits.
  localparam int unsigned SumWidth = ACC_WIDTH - 1;
  localparam int unsigned PadWidth = SumWidth - ADC_WIDTH;

  cds_state_e                  state_q;
  logic                        running_q, base_q, sig_q;
  logic [SKIP_WIDTH-1:0]       n_q, skip_cnt_q;
  logic [SumWidth-1:0]         base_sum_q, sig_sum_q;
  logic signed [ACC_WIDTH-1:0] acc_q, pix_data_q;
  logic                        pix_valid_q;
  logic [ErrWidth-1:0]         err_q;

  logic                        run_rise, run_fall, sig_fall;
  logic                        base_hit, sig_hit, overlap, start;
  logic [SumWidth-1:0]         sample, base_sat, sig_sat;
  logic [SumWidth:0]           base_add, sig_add;
  logic                        base_ovf, sig_ovf;
  logic [SKIP_WIDTH-1:0]       skip_inc, n_load;
  logic signed [ACC_WIDTH-1:0] diff, acc_sat;
  logic                        acc_ovf;

  // Edge detects, window classification and saturating window sums.
  always_comb begin
    run_rise = bus_io.running & ~running_q;
    run_fall = ~bus_io.running & running_q;
    sig_fall = ~bus_io.sig_win & sig_q;
    base_hit = bus_io.adc_valid & bus_io.base_win & ~bus_io.sig_win;
    sig_hit  = bus_io.adc_valid & bus_io.sig_win & ~bus_io.base_win;
    overlap  = bus_io.adc_valid & bus_io.base_win & bus_io.sig_win;
    sample   = {{PadWidth{1'b0}}, bus_io.adc_data};
    base_add = {1'b0, base_sum_q} + {1'b0, sample};
    sig_add  = {1'b0, sig_sum_q} + {1'b0, sample};
    base_ovf = base_add[SumWidth];
    sig_ovf  = sig_add[SumWidth];
    base_sat = base_ovf ? '1 : base_add[SumWidth-1:0];
    sig_sat  = sig_ovf ? '1 : sig_add[SumWidth-1:0];
    diff     = $signed({1'b0, sig_sum_q}) - $signed({1'b0, base_sum_q});
    skip_inc = skip_cnt_q + SKIP_WIDTH'(1);
    n_load   = (bus_io.num_skips == '0) ? SKIP_WIDTH'(1) : bus_io.num_skips;
    start    = run_rise & ((state_q == IDLE) | ((state_q == OUT) & bus_io.pix_ready));
  end

  sat_add #(
    .Width (ACC_WIDTH)
  ) u_acc_add (
    .a_i   (acc_q),
    .b_i   (diff),
    .sum_o (acc_sat),
    .ovf_o (acc_ovf)
  );

  // Pattern signals are registered every cycle, independent of state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_q <= 1'b0;
      base_q    <= 1'b0;
      sig_q     <= 1'b0;
    end else begin
      running_q <= bus_io.running;
      base_q    <= bus_io.base_win;
      sig_q     <= bus_io.sig_win;
    end
  end

  // Main FSM with all datapath state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      skip_cnt_q  <= '0;
      base_sum_q  <= '0;
      sig_sum_q   <= '0;
      acc_q       <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      err_q       <= '0;
    end else if (start) begin
      state_q     <= ACQ;
      n_q         <= n_load;
      skip_cnt_q  <= '0;
      base_sum_q  <= '0;
      sig_sum_q   <= '0;
      acc_q       <= '0;
      pix_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      case (state_q)
        ACQ: begin
          if (sig_fall) begin
            acc_q      <= acc_sat;
            skip_cnt_q <= skip_inc;
            // A baseline sample landing on the edge cycle opens the next skip.
            base_sum_q <= base_hit ? sample : '0;
            sig_sum_q  <= '0;
            if (acc_ovf) err_q[ErrSat] <= 1'b1;
            if (skip_inc == n_q) begin
              pix_data_q  <= acc_sat;
              pix_valid_q <= 1'b1;
              state_q     <= OUT;
            end else if (run_fall) begin
              err_q[ErrAbort] <= 1'b1;
              state_q         <= IDLE;
            end
          end else if (run_fall) begin
            err_q[ErrAbort] <= 1'b1;
            base_sum_q      <= '0;
            sig_sum_q       <= '0;
            acc_q           <= '0;
            state_q         <= IDLE;
          end else begin
            if (base_hit) begin
              base_sum_q <= base_sat;
              if (base_ovf) err_q[ErrSat] <= 1'b1;
            end
            if (sig_hit) begin
              sig_sum_q <= sig_sat;
              if (sig_ovf) err_q[ErrSat] <= 1'b1;
            end
          end
          if (overlap) err_q[ErrOverlap] <= 1'b1;
        end
        OUT: begin
          if (bus_io.pix_ready) begin
            pix_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (run_rise) begin
            err_q[ErrAbort] <= 1'b1;
          end
        end
        IDLE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.pix_data  = pix_data_q;
  assign bus_io.pix_valid = pix_valid_q;
  assign bus_io.busy      = (state_q != IDLE);
  assign bus_io.skip_cnt  = skip_cnt_q;
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_cds_accumulator.sv
// Directed bench: a default-width DUT and an 18-bit accumulator DUT share stimulus.
module tb_cds_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        running = 1'b0;
  logic        base_win = 1'b0;
  logic        sig_win = 1'b0;
  logic [15:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [15:0] num_skips = '0;
  logic        pix_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cds_accumulator_if #(.ADC_WIDTH(16), .ACC_WIDTH(32), .SKIP_WIDTH(16)) if0 ();
  cds_accumulator_if #(.ADC_WIDTH(16), .ACC_WIDTH(18), .SKIP_WIDTH(16)) if1 ();

  assign if0.running = running;    assign if1.running = running;
  assign if0.base_win = base_win;  assign if1.base_win = base_win;
  assign if0.sig_win = sig_win;    assign if1.sig_win = sig_win;
  assign if0.adc_data = adc_data;  assign if1.adc_data = adc_data;
  assign if0.adc_valid = adc_valid; assign if1.adc_valid = adc_valid;
  assign if0.num_skips = num_skips; assign if1.num_skips = num_skips;
  assign if0.pix_ready = pix_ready; assign if1.pix_ready = pix_ready;

  cds_accumulator #(.ADC_WIDTH(16), .ACC_WIDTH(32), .SKIP_WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (if0)
  );

  cds_accumulator #(.ADC_WIDTH(16), .ACC_WIDTH(18), .SKIP_WIDTH(16)) dut18 (
    .clk    (clk),
    .reset  (reset),
    .bus_io (if1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One skip: baseline sample, signal sample, then signal window falls.
  task automatic skip(input logic [15:0] b, input logic [15:0] s);
    base_win = 1'b1; adc_valid = 1'b1; adc_data = b; tick();
    base_win = 1'b0; sig_win = 1'b1; adc_data = s; tick();
    adc_valid = 1'b0; adc_data = '0; sig_win = 1'b0; tick();
  endtask

  task automatic start_pixel(input logic [15:0] n);
    num_skips = n; running = 1'b1; tick();
  endtask

  task automatic finish_pixel();
    pix_ready = 1'b1; tick();
    pix_ready = 1'b0; running = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    n_checks++; if (if0.pix_data !== 32'sd0) begin n_errors++;
      $display("FAIL reset pix_data got %0d want 0", if0.pix_data); end
    n_checks++; if (if0.pix_valid !== 1'b0) begin n_errors++;
      $display("FAIL reset pix_valid got %b want 0", if0.pix_valid); end
    n_checks++; if (if0.busy !== 1'b0) begin n_errors++;
      $display("FAIL reset busy got %b want 0", if0.busy); end
    n_checks++; if (if0.skip_cnt !== 16'd0) begin n_errors++;
      $display("FAIL reset skip_cnt got %0d want 0", if0.skip_cnt); end
    n_checks++; if (if0.err !== 3'b000) begin n_errors++;
      $display("FAIL reset err got %b want 000", if0.err); end
  endtask

  task automatic test_basic();
    start_pixel(16'd4);
    n_checks++; if (if0.busy !== 1'b1) begin n_errors++;
      $display("FAIL basic busy got %b want 1", if0.busy); end
    for (int k = 1; k <= 3; k++) begin
      skip(16'd100, 16'd300);
      n_checks++; if (if0.skip_cnt !== 16'(k)) begin n_errors++;
        $display("FAIL basic skip_cnt got %0d want %0d", if0.skip_cnt, k); end
    end
    n_checks++; if (if0.pix_valid !== 1'b0) begin n_errors++;
      $display("FAIL basic early pix_valid got %b want 0", if0.pix_valid); end
    skip(16'd100, 16'd300);
    n_checks++; if (if0.pix_valid !== 1'b1) begin n_errors++;
      $display("FAIL basic pix_valid got %b want 1", if0.pix_valid); end
    n_checks++; if (if0.pix_data !== 32'sd800) begin n_errors++;
      $display("FAIL basic pix_data got %0d want 800", if0.pix_data); end
    n_checks++; if (if0.err !== 3'b000) begin n_errors++;
      $display("FAIL basic err got %b want 000", if0.err); end
    pix_ready = 1'b1; tick();
    n_checks++; if (if0.pix_valid !== 1'b0 || if0.busy !== 1'b0) begin n_errors++;
      $display("FAIL basic handshake valid/busy got %b%b want 00", if0.pix_valid, if0.busy); end
    pix_ready = 1'b0; running = 1'b0; tick();
  endtask

  task automatic test_zero_skips();
    start_pixel(16'd0);
    skip(16'd50, 16'd20);
    n_checks++; if (if0.pix_valid !== 1'b1) begin n_errors++;
      $display("FAIL zero_skips pix_valid got %b want 1", if0.pix_valid); end
    n_checks++; if (if0.pix_data !== -32'sd30) begin n_errors++;
      $display("FAIL zero_skips pix_data got %0d want -30", if0.pix_data); end
    n_checks++; if (if0.skip_cnt !== 16'd1) begin n_errors++;
      $display("FAIL zero_skips skip_cnt got %0d want 1", if0.skip_cnt); end
    finish_pixel();
  endtask

  task automatic test_saturation();
    start_pixel(16'd8);
    for (int k = 0; k < 8; k++) skip(16'd0, 16'd65535);
    n_checks++; if (if1.pix_data !== 18'sd131071) begin n_errors++;
      $display("FAIL sat pix_data got %0d want 131071", if1.pix_data); end
    n_checks++; if (if1.err[0] !== 1'b1) begin n_errors++;
      $display("FAIL sat err0 got %b want 1", if1.err[0]); end
    n_checks++; if (if0.pix_data !== 32'sd524280 || if0.err !== 3'b000) begin n_errors++;
      $display("FAIL sat wide pix_data/err got %0d/%b want 524280/000", if0.pix_data, if0.err);
    end
    finish_pixel();
  endtask

  task automatic test_overlap();
    start_pixel(16'd1);
    base_win = 1'b1; adc_valid = 1'b1; adc_data = 16'd100; tick();
    sig_win = 1'b1; adc_data = 16'd999; tick();
    base_win = 1'b0; adc_data = 16'd300; tick();
    adc_valid = 1'b0; sig_win = 1'b0; tick();
    n_checks++; if (if0.pix_data !== 32'sd200) begin n_errors++;
      $display("FAIL overlap pix_data got %0d want 200", if0.pix_data); end
    n_checks++; if (if0.err !== 3'b010) begin n_errors++;
      $display("FAIL overlap err got %b want 010", if0.err); end
    finish_pixel();
  endtask

  task automatic test_abort();
    start_pixel(16'd4);
    skip(16'd100, 16'd300);
    skip(16'd100, 16'd300);
    running = 1'b0; tick();
    n_checks++; if (if0.busy !== 1'b0 || if0.pix_valid !== 1'b0) begin n_errors++;
      $display("FAIL abort busy/valid got %b%b want 00", if0.busy, if0.pix_valid); end
    n_checks++; if (if0.err !== 3'b100) begin n_errors++;
      $display("FAIL abort err got %b want 100", if0.err); end
    tick();
  endtask

  task automatic test_coincide();
    start_pixel(16'd1);
    base_win = 1'b1; adc_valid = 1'b1; adc_data = 16'd10; tick();
    base_win = 1'b0; sig_win = 1'b1; adc_data = 16'd40; tick();
    adc_valid = 1'b0; sig_win = 1'b0; running = 1'b0; tick();
    n_checks++; if (if0.pix_valid !== 1'b1 || if0.pix_data !== 32'sd30) begin n_errors++;
      $display("FAIL coincide valid/data got %b/%0d want 1/30", if0.pix_valid, if0.pix_data);
    end
    n_checks++; if (if0.err !== 3'b000) begin n_errors++;
      $display("FAIL coincide err got %b want 000", if0.err); end
    finish_pixel();
  endtask

  task automatic test_backpressure();
    start_pixel(16'd1);
    skip(16'd0, 16'd5);
    running = 1'b0; tick();
    running = 1'b1; tick();
    for (int k = 0; k < 8; k++) tick();
    n_checks++; if (if0.pix_valid !== 1'b1 || if0.pix_data !== 32'sd5) begin n_errors++;
      $display("FAIL backpressure valid/data got %b/%0d want 1/5", if0.pix_valid, if0.pix_data);
    end
    n_checks++; if (if0.err !== 3'b100 || if0.busy !== 1'b1) begin n_errors++;
      $display("FAIL backpressure err/busy got %b/%b want 100/1", if0.err, if0.busy); end
  endtask

  task automatic test_back_to_back();
    running = 1'b0; tick();
    num_skips = 16'd1; running = 1'b1; pix_ready = 1'b1; tick();
    pix_ready = 1'b0;
    n_checks++; if (if0.pix_valid !== 1'b0 || if0.busy !== 1'b1) begin n_errors++;
      $display("FAIL b2b valid/busy got %b%b want 01", if0.pix_valid, if0.busy); end
    n_checks++; if (if0.err !== 3'b000 || if0.skip_cnt !== 16'd0) begin n_errors++;
      $display("FAIL b2b err/skip_cnt got %b/%0d want 000/0", if0.err, if0.skip_cnt); end
    skip(16'd0, 16'd9);
    n_checks++; if (if0.pix_valid !== 1'b1 || if0.pix_data !== 32'sd9) begin n_errors++;
      $display("FAIL b2b result got %b/%0d want 1/9", if0.pix_valid, if0.pix_data); end
  endtask

  task automatic test_reset_mid_out();
    running = 1'b0; tick();
    running = 1'b1; tick();
    n_checks++; if (if0.err !== 3'b100) begin n_errors++;
      $display("FAIL mid_out pre-reset err got %b want 100", if0.err); end
    reset = 1'b1; tick();
    n_checks++; if (if0.pix_data !== 32'sd0 || if0.pix_valid !== 1'b0) begin n_errors++;
      $display("FAIL mid_out data/valid got %0d/%b want 0/0", if0.pix_data, if0.pix_valid); end
    n_checks++; if (if0.busy !== 1'b0 || if0.skip_cnt !== 16'd0 || if0.err !== 3'b000) begin
      n_errors++;
      $display("FAIL mid_out busy/skip/err got %b/%0d/%b want 0/0/000",
               if0.busy, if0.skip_cnt, if0.err);
    end
    reset = 1'b0; running = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_skips();
    test_saturation();
    test_overlap();
    test_abort();
    test_coincide();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_out();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cds_accumulator.md
CDS_ACCUMULATOR -- requirements
Module: cds_accumulator

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 16: unsigned ADC sample width.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: signed pixel result width; must be at least ADC_WIDTH+2.
REQ-003 SHALL have parameter SKIP_WIDTH, default 16: skip-count width.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port running, input, 1 bit: pattern-active flag from the CIS control stage.
REQ-007 SHALL have port base_win, input, 1 bit: baseline sampling window (pattern signal).
REQ-008 SHALL have port sig_win, input, 1 bit: signal sampling window (pattern signal).
REQ-009 SHALL have port adc_data, input, ADC_WIDTH bits: unsigned ADC sample.
REQ-010 SHALL have port adc_valid, input, 1 bit: adc_data valid this cycle.
REQ-011 SHALL have port num_skips, input, SKIP_WIDTH bits: skips per pixel.
REQ-012 SHALL have port pix_data, output, ACC_WIDTH bits: signed CDS sum over all skips.
REQ-013 SHALL have port pix_valid, output, 1 bit: pix_data available.
REQ-014 SHALL have port pix_ready, input, 1 bit: consumer accepts pix_data.
REQ-015 SHALL have port busy, output, 1 bit: high in ACQ or OUT.
REQ-016 SHALL have port skip_cnt, output, SKIP_WIDTH bits: skips completed for the current pixel.
REQ-017 SHALL have port err, output, 3 bits, sticky: [0] saturation, [1] window overlap, [2] overrun/abort.

Function
REQ-018 SHALL register running, base_win and sig_win every cycle (running_q, base_q, sig_q) for edge detection.
REQ-019 SHALL implement FSM IDLE/ACQ/OUT; reset state IDLE.
REQ-020 IDLE->ACQ on running rising edge: latch n = max(num_skips,1); clear sums, acc, skip_cnt and err.
REQ-021 In ACQ, adc_valid with base_win=1, sig_win=0 SHALL add zero-extended adc_data to base_sum; with sig_win=1, base_win=0 SHALL add it to sig_sum.
REQ-022 adc_valid with both windows high SHALL discard the sample and set err[1].
REQ-023 On sig_win falling edge in ACQ: acc <= sat(acc + sig_sum - base_sum); clear both sums; skip_cnt += 1.
REQ-024 If that skip makes skip_cnt == n, the same edge SHALL load pix_data with the saturated result and move to OUT; pix_valid SHALL be high the cycle after sig_win is first seen low.
REQ-025 Any addition exceeding signed ACC_WIDTH range SHALL clamp to max/min and set err[0]; base_sum and sig_sum SHALL saturate at all-ones.
REQ-026 Running falling edge in ACQ with skip_cnt < n SHALL discard the data, set err[2], and return to IDLE.
REQ-027 When the running falling edge and the final sig_win falling edge coincide, the pixel SHALL complete normally.
REQ-028 In OUT, pix_valid=1 and pix_data stable until pix_valid & pix_ready; then ->IDLE, or directly ->ACQ with REQ-020 actions if a running rising edge occurs that cycle.
REQ-029 A running rising edge in OUT without pix_ready SHALL set err[2] and ignore that pixel; OUT SHALL hold.
REQ-030 Window samples in IDLE or OUT SHALL be ignored.

Reset
REQ-031 Reset SHALL force IDLE, pix_data=0, pix_valid=0, busy=0, skip_cnt=0, err=0, all sums and edge registers 0, regardless of state, including mid-ACQ or mid-OUT.

Structure
REQ-032 A shared package cis_pkg SHALL hold the state enum (IDLE, ACQ, OUT) and the err bit-index constants.
REQ-033 A single sub-module sat_add SHALL perform the signed saturating add and report overflow; it SHALL be instantiated for acc.

Verification
REQ-034 n=4; each skip has one base sample 100 and one signal sample 300 -> pix_data=800, pix_valid one cycle after the 4th sig_win fall, err=0.
REQ-035 num_skips=0; one skip with base 50 and signal 20 -> pix_data=-30, skip_cnt=1.
REQ-036 ACC_WIDTH=18, ADC_WIDTH=16, n=8; base 0 and signal 65535 each skip -> pix_data=131071, err[0]=1.
REQ-037 Base and signal windows overlap on one valid sample -> sample discarded, err[1]=1, result excludes it.
REQ-038 running falls after 2 of 4 skips -> IDLE, no pix_valid, err[2]=1.
REQ-039 pix_ready held low 10 cycles while a new running edge arrives -> pix_data held, err[2]=1; reset asserted mid-OUT -> all outputs 0 next cycle.
